// File: rtl/metadata_pkg.sv
// Shared encodings and helpers for the N-way cache metadata array.
package metadata_pkg;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/metadata_lru.sv
// True-LRU victim selection and age update for one set.
module metadata_lru
  import metadata_pkg::*;
#(
  parameter int unsigned WAYS  = 2,
  parameter int unsigned WAY_W = clog2(WAYS)
) (
  input  logic [WAYS-1:0][WAY_W-1:0] age,
  input  logic [WAYS-1:0]            valid,
  input  logic [WAY_W-1:0]           acc_way,
  output logic [WAY_W-1:0]           victim,
  output logic [WAYS-1:0][WAY_W-1:0] age_next
);

  logic             found;
  logic [WAY_W-1:0] old_age;

  always_comb begin
    victim = '0;
    found  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid[w]) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age[w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
      end
    end
  end

  // Accessed way becomes youngest; only ways younger than it age by one.
  always_comb begin
    old_age = age[acc_way];
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == acc_way) begin
        age_next[w] = '0;
      end else if (age[w] < old_age) begin
        age_next[w] = age[w] + 1'b1;
      end else begin
        age_next[w] = age[w];
      end
    end
  end

endmodule

// File: rtl/metadata_array_nway.sv
// N-way set-associative metadata array: valid/dirty/tag per way, true-LRU per set,
// one-cycle registered lookup response and a set-by-set flush sweep.
module metadata_array_nway
  import metadata_pkg::*;
#(
  parameter int unsigned WAYS  = 2,
  parameter int unsigned SETS  = 64,
  parameter int unsigned TAG_W = 6,
  localparam int unsigned WAY_W = clog2(WAYS),
  localparam int unsigned SET_W = clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [SET_W-1:0] req_set,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             busy,
  output logic             rsp_valid,
  output logic             rsp_hit,
  output logic [WAY_W-1:0] rsp_way,
  output logic             rsp_victim_valid,
  output logic             rsp_victim_dirty,
  output logic [TAG_W-1:0] rsp_victim_tag
);

  typedef logic [WAYS-1:0][WAY_W-1:0] age_t;

  state_e           state_q;
  logic [SET_W-1:0] flush_set_q;

  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-1:0]  dirty_q [SETS];
  age_t             age_q   [SETS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];

  logic             accept;
  logic [WAYS-1:0]  set_valid;
  logic [WAYS-1:0]  set_dirty;
  age_t             set_age;
  age_t             age_next;
  logic [WAYS-1:0]  hit_vec;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim_way;
  logic [WAY_W-1:0] acc_way;
  logic             is_hit;
  logic             is_fill;
  logic             is_write;
  logic             fill_miss;
  logic             evict_valid;

  function automatic age_t init_age();
    age_t a;
    for (int w = 0; w < WAYS; w++) a[w] = WAY_W'(w);
    return a;
  endfunction

  assign req_ready = (state_q == ST_IDLE) && !flush;
  assign accept    = req_valid && req_ready;
  assign busy      = (state_q == ST_FLUSH);

  assign set_valid = valid_q[req_set];
  assign set_dirty = dirty_q[req_set];
  assign set_age   = age_q[req_set];

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = set_valid[w] && (tag_q[req_set][w] == req_tag);
      if (hit_vec[w]) hit_way = hit_way | WAY_W'(w);
    end
  end

  assign is_hit      = |hit_vec;
  assign is_fill     = (req_op == OP_FILL);
  assign is_write    = (req_op == OP_WRITE);
  assign fill_miss   = is_fill && !is_hit;
  assign acc_way     = is_hit ? hit_way : victim_way;
  assign evict_valid = fill_miss && set_valid[victim_way];

  metadata_lru #(
    .WAYS  (WAYS),
    .WAY_W (WAY_W)
  ) u_lru (
    .age      (set_age),
    .valid    (set_valid),
    .acc_way  (acc_way),
    .victim   (victim_way),
    .age_next (age_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      flush_set_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        age_q[s]   <= init_age();
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (flush) begin
            state_q     <= ST_FLUSH;
            flush_set_q <= '0;
          end else if (accept && (is_hit || is_fill)) begin
            // Lookup misses leave the set untouched.
            age_q[req_set] <= age_next;
            if (is_hit && is_write) dirty_q[req_set][hit_way] <= 1'b1;
            if (fill_miss) begin
              valid_q[req_set][victim_way] <= 1'b1;
              dirty_q[req_set][victim_way] <= 1'b0;
            end
          end
        end
        ST_FLUSH: begin
          valid_q[flush_set_q] <= '0;
          dirty_q[flush_set_q] <= '0;
          age_q[flush_set_q]   <= init_age();
          if (flush_set_q == SET_W'(SETS - 1)) begin
            state_q <= ST_IDLE;
          end else begin
            flush_set_q <= flush_set_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Tags carry no reset; valid gates every use of them.
  always_ff @(posedge clk) begin
    if (accept && fill_miss) tag_q[req_set][victim_way] <= req_tag;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid        <= 1'b0;
      rsp_hit          <= 1'b0;
      rsp_way          <= '0;
      rsp_victim_valid <= 1'b0;
      rsp_victim_dirty <= 1'b0;
      rsp_victim_tag   <= '0;
    end else begin
      rsp_valid <= accept;
      if (accept) begin
        rsp_hit          <= is_hit;
        rsp_way          <= acc_way;
        rsp_victim_valid <= evict_valid;
        rsp_victim_dirty <= evict_valid && set_dirty[victim_way];
        rsp_victim_tag   <= evict_valid ? tag_q[req_set][victim_way] : '0;
      end
    end
  end

endmodule

// File: tb/tb_metadata_array_nway.sv
// Scoreboard bench: a 2-way and a 4-way instance, directed vectors, decoupled monitor.
module tb_metadata_array_nway;

  typedef struct packed {
    logic        hit;
    logic [1:0]  way;
    logic        vv;
    logic        vd;
    logic [5:0]  vtag;
    logic [31:0] due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  exp_t q2[$];
  exp_t q4[$];

  logic       rst2, rv2, fl2, rr2, busy2, rvo2, hit2, way2, vv2, vd2;
  logic [1:0] op2;
  logic [2:0] set2;
  logic [5:0] tag2, vt2;

  logic       rst4, rv4, fl4, rr4, busy4, rvo4, hit4, vv4, vd4;
  logic [1:0] op4, way4;
  logic [2:0] set4;
  logic [5:0] tag4, vt4;

  metadata_array_nway #(.WAYS(2), .SETS(8), .TAG_W(6)) u_dut2 (
    .clk(clk), .rst(rst2), .req_valid(rv2), .req_ready(rr2), .req_op(op2),
    .req_set(set2), .req_tag(tag2), .flush(fl2), .busy(busy2), .rsp_valid(rvo2),
    .rsp_hit(hit2), .rsp_way(way2), .rsp_victim_valid(vv2), .rsp_victim_dirty(vd2),
    .rsp_victim_tag(vt2)
  );

  metadata_array_nway #(.WAYS(4), .SETS(8), .TAG_W(6)) u_dut4 (
    .clk(clk), .rst(rst4), .req_valid(rv4), .req_ready(rr4), .req_op(op4),
    .req_set(set4), .req_tag(tag4), .flush(fl4), .busy(busy4), .rsp_valid(rvo4),
    .rsp_hit(hit4), .rsp_way(way4), .rsp_victim_valid(vv4), .rsp_victim_dirty(vd4),
    .rsp_victim_tag(vt4)
  );

  task automatic expect_eq(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic check_rsp(input int d, input logic hit, input logic [1:0] way, input logic vv,
                           input logic vd, input logic [5:0] vtag);
    exp_t e;
    checks++;
    if ((d == 0 && q2.size() == 0) || (d == 1 && q4.size() == 0)) begin
      errors++;
      $display("FAIL unexpected_rsp dut%0d: got rsp_valid=1 at cycle %0d want none", d, cyc);
      return;
    end
    e = (d == 0) ? q2.pop_front() : q4.pop_front();
    if (hit !== e.hit || way !== e.way || vv !== e.vv || vd !== e.vd || vtag !== e.vtag ||
        cyc != int'(e.due)) begin
      errors++;
      $display("FAIL rsp dut%0d: got hit=%0b way=%0d vv=%0b vd=%0b vtag=%h cyc=%0d want hit=%0b way=%0d vv=%0b vd=%0b vtag=%h cyc=%0d",
               d, hit, way, vv, vd, vtag, cyc, e.hit, e.way, e.vv, e.vd, e.vtag, e.due);
    end
  endtask

  always @(negedge clk) begin
    if (rst2 && rvo2) check_rsp(0, hit2, {1'b0, way2}, vv2, vd2, vt2);
    if (rst4 && rvo4) check_rsp(1, hit4, way4, vv4, vd4, vt4);
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic issue(input int d, input logic [1:0] op, input logic [2:0] set,
                       input logic [5:0] tag, input logic hit, input logic [1:0] way,
                       input logic vv, input logic vd, input logic [5:0] vtag);
    exp_t e;
    int   n;
    n = 0;
    if (d == 0) begin rv2 = 1'b1; op2 = op; set2 = set; tag2 = tag; end
    else        begin rv4 = 1'b1; op4 = op; set4 = set; tag4 = tag; end
    while (!((d == 0) ? rr2 : rr4) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n == 20) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout dut%0d: got req_ready=0 want 1", d);
    end else begin
      e = '{hit, way, vv, vd, vtag, 32'(cyc + 1)};
      if (d == 0) q2.push_back(e); else q4.push_back(e);
      @(posedge clk); #1;
    end
    if (d == 0) rv2 = 1'b0; else rv4 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    rst2 = 0; rv2 = 0; fl2 = 0; op2 = 0; set2 = 0; tag2 = 0;
    rst4 = 0; rv4 = 0; fl4 = 0; op4 = 0; set4 = 0; tag4 = 0;
    repeat (3) @(posedge clk);
    #1;
    rst2 = 1; rst4 = 1;
    @(negedge clk);
    expect_eq("reset_ready2", 32'(rr2), 1);
    expect_eq("reset_busy2", 32'(busy2), 0);
    expect_eq("reset_rsp2", {hit2, way2, vv2, vd2, vt2, rvo2}, 0);
    expect_eq("reset_ready4", 32'(rr4), 1);
    expect_eq("reset_busy4", 32'(busy4), 0);
    @(posedge clk); #1;

    // 2-way, set 3
    issue(0, 2'b00, 3, 6'h0A, 0, 0, 0, 0, 6'h00);
    issue(0, 2'b10, 3, 6'h0A, 0, 0, 0, 0, 6'h00);
    issue(0, 2'b00, 3, 6'h0A, 1, 0, 0, 0, 6'h00);
    issue(0, 2'b10, 3, 6'h03, 0, 1, 0, 0, 6'h00);
    issue(0, 2'b00, 3, 6'h03, 1, 1, 0, 0, 6'h00);
    issue(0, 2'b00, 3, 6'h0A, 1, 0, 0, 0, 6'h00);
    issue(0, 2'b10, 3, 6'h15, 0, 1, 1, 0, 6'h03);
    issue(0, 2'b01, 3, 6'h0A, 1, 0, 0, 0, 6'h00);
    issue(0, 2'b00, 3, 6'h15, 1, 1, 0, 0, 6'h00);
    issue(0, 2'b10, 3, 6'h20, 0, 0, 1, 1, 6'h0A);
    issue(0, 2'b11, 3, 6'h20, 1, 0, 0, 0, 6'h00);
    issue(0, 2'b10, 3, 6'h20, 1, 0, 0, 0, 6'h00);
    repeat (2) @(posedge clk);
    #1;

    // Flush pulse with a request held pending throughout
    rv2 = 1; op2 = 2'b00; set2 = 3; tag2 = 6'h15; fl2 = 1;
    #1 expect_eq("flush_entry_ready", 32'(rr2), 0);
    @(posedge clk); #1;
    fl2 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      expect_eq($sformatf("flush_busy_%0d", i), 32'(busy2), 1);
      expect_eq($sformatf("flush_ready_%0d", i), 32'(rr2), 0);
    end
    @(posedge clk); #1;
    expect_eq("flush_done_busy", 32'(busy2), 0);
    expect_eq("flush_done_ready", 32'(rr2), 1);
    rv2 = 0;
    issue(0, 2'b00, 3, 6'h15, 0, 0, 0, 0, 6'h00);
    issue(0, 2'b00, 3, 6'h20, 0, 0, 0, 0, 6'h00);

    // 4-way, set 0
    issue(1, 2'b10, 0, 6'd1, 0, 0, 0, 0, 6'h00);
    issue(1, 2'b10, 0, 6'd2, 0, 1, 0, 0, 6'h00);
    issue(1, 2'b10, 0, 6'd3, 0, 2, 0, 0, 6'h00);
    issue(1, 2'b10, 0, 6'd4, 0, 3, 0, 0, 6'h00);
    issue(1, 2'b00, 0, 6'd1, 1, 0, 0, 0, 6'h00);
    issue(1, 2'b10, 0, 6'd5, 0, 1, 1, 0, 6'd2);
    issue(1, 2'b00, 0, 6'd3, 1, 2, 0, 0, 6'h00);
    repeat (2) @(posedge clk);
    #1;

    // Reset asserted in the middle of a flush sweep
    fl4 = 1;
    @(posedge clk); #1;
    fl4 = 0;
    expect_eq("flush4_busy", 32'(busy4), 1);
    @(posedge clk); #1;
    rst4 = 0;
    #1 expect_eq("rst_mid_flush_busy", 32'(busy4), 0);
    @(negedge clk);
    rst4 = 1;
    @(posedge clk); #1;
    expect_eq("post_rst_busy", 32'(busy4), 0);
    issue(1, 2'b00, 0, 6'd1, 0, 0, 0, 0, 6'h00);

    repeat (3) @(posedge clk);
    #1;
    expect_eq("q2_drained", 32'(q2.size()), 0);
    expect_eq("q4_drained", 32'(q4.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/metadata_array_nway.md
Name: metadata_array_nway

Overview:
- Parametrised N-way set-associative cache metadata array holding valid, dirty and tag per way, plus true-LRU age per set.
- Successor to the fixed 2-way single-set metadata block.
- Adds configurable sets, ways and tag width, dirty tracking, victim reporting, a registered request/response handshake and a runtime flush sweep.
- Sits beside the data array in the cache controller; the controller uses rsp_way and the victim fields to steer data-array access and write-back.

Parameters:
- WAYS, 2, associativity; power of two, 2..8.
- SETS, 64, number of sets; power of two, 2..256.
- TAG_W, 6, tag width in bits.
- Derived: WAY_W = clog2(WAYS), SET_W = clog2(SETS).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset; rst==0 resets immediately.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted this cycle when high together with req_valid.
- req_op  input  2  00 read-lookup, 01 write-lookup, 10 fill, 11 treated as read-lookup.
- req_set  input  SET_W  set index.
- req_tag  input  TAG_W  tag.
- flush  input  1  invalidate-all request (level sampled).
- busy  output  1  flush sweep in progress.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_hit  output  1  tag matched a valid way.
- rsp_way  output  WAY_W  hit way, or the allocated/victim way on a miss.
- rsp_victim_valid  output  1  fill evicted a valid line.
- rsp_victim_dirty  output  1  the evicted line was dirty.
- rsp_victim_tag  output  TAG_W  tag of the evicted line.

Behaviour:
- Storage is flops. valid, dirty and age reset asynchronously: valid=0, dirty=0, age[w]=w. Tags are not reset.
- Reset values of outputs: all rsp_* = 0, busy=0, req_ready=1 once rst is released.
- States: IDLE and FLUSH.
- req_ready = (state==IDLE) && !flush.
- Acceptance edge: lookup is evaluated combinationally from current state; the result is registered; rsp_valid is high exactly one cycle later. Latency is 1. Back-to-back requests are allowed; the state update from request N is visible to request N+1.
- Victim selection: lowest-index invalid way; if all ways are valid, the way with age==WAYS-1.
- LRU update on accessing way a with old age k: age[a]=0; every way with age<k increments by 1. Ages always remain a permutation of 0..WAYS-1.
- Read-lookup hit: rsp_hit=1, rsp_way=hit way, LRU updated.
- Write-lookup hit: as read-lookup hit, and additionally dirty[way]=1.
- Lookup miss (read or write): rsp_hit=0, rsp_way=victim, rsp_victim_* = 0, no state change.
- Fill that hits: treated as a read-lookup hit; no allocation.
- Fill that misses: victim way gets valid=1, dirty=0, tag=req_tag, LRU updated. rsp_hit=0, rsp_way=victim. rsp_victim_valid/dirty/tag report the prior contents of that way; rsp_victim_tag=0 when rsp_victim_valid=0.
- Hit detection: at most one way may match; ways with valid=0 never match.
- Flush:
  - In IDLE with flush=1, enter FLUSH; a request is not accepted in that cycle.
  - The set counter steps 0..SETS-1, one set per cycle, clearing valid/dirty and restoring age[w]=w.
  - busy=1 for exactly SETS cycles, then return to IDLE.
  - flush is ignored while busy.
  - A response to a request accepted before the flush began still emits normally.
- Reset mid-flush: state forced to IDLE; all lines invalid.

Decomposition:
- Package metadata_pkg holds:
  - op encodings OP_READ=2'b00, OP_WRITE=2'b01, OP_FILL=2'b10;
  - state encodings ST_IDLE, ST_FLUSH;
  - a clog2 function.
- One sub-module: metadata_lru, a combinational block. Inputs: one set's age vector and valid bits, plus the accessed way. Outputs: the victim way and the next age vector. Instantiated once on the selected set.

Test Plan (WAYS=2, SETS=8, TAG_W=6 unless noted):
1. Release reset; read set 3 tag 0x0A -> rsp_valid 1 cycle later; rsp_hit=0, rsp_way=0, rsp_victim_valid=0.
2. Fill set3 tag 0x0A, then read it -> fill: rsp_hit=0, rsp_way=0; read: rsp_hit=1, rsp_way=0. Fill tag 0x03, then read it -> fill: rsp_way=1; read: rsp_hit=1, rsp_way=1.
3. Read 0x0A, then fill 0x15 in set3 -> rsp_way=1, rsp_victim_valid=1, rsp_victim_tag=0x03, rsp_victim_dirty=0.
4. Write-lookup 0x0A (hit, way0), read 0x15, then fill 0x20 -> rsp_way=0, rsp_victim_tag=0x0A, rsp_victim_dirty=1.
5. Pulse flush with req_valid held high -> busy=1 and req_ready=0 for exactly 8 cycles; no rsp_valid generated. Afterwards read 0x15 -> rsp_hit=0, rsp_way=0.
6. WAYS=4:
   - Fill tags 1,2,3,4 into set0 -> ways 0,1,2,3.
   - Read tag 1, then fill tag 5 -> rsp_way=1, rsp_victim_tag=2.
   - Assert rst=0 during a subsequent flush -> busy=0 immediately; read tag 1 misses.
